// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with busy scoreboard and one-entry-per-cycle flush.
// Optional same-cycle write-to-read forwarding is compiled in with REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [AW-1:0]         wa0,
  input  logic [AW-1:0]         wa1,
  input  logic [XLEN-1:0]       wd0,
  input  logic [XLEN-1:0]       wd1,
  input  logic                  iss_valid,
  input  logic [AW-1:0]         iss_addr,
  input  logic                  flush_req,
  output logic                  flush_busy
);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [AW-1:0]   fcnt_r;
  logic [AW-1:0]   fcnt_nx_s;
  logic            idle_s;
  logic            clear_s;
  logic            start_s;
  logic [XLEN-1:0] mem_r [NREGS];
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nx_s;

  // flush sequencer state register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      fcnt_r  <= {AW{1'b0}};
    end else begin
      state_r <= state_nx_s;
      fcnt_r  <= fcnt_nx_s;
    end
  end

  // flush sequencer next state; fcnt wraps to 0 after the last entry
  always_comb begin
    state_nx_s = state_r;
    fcnt_nx_s  = fcnt_r;
    case (state_r)
      IDLE: begin
        if (flush_req) begin
          state_nx_s = CLEAR;
          fcnt_nx_s  = {{(AW-1){1'b0}}, 1'b1};
        end else begin
          state_nx_s = IDLE;
          fcnt_nx_s  = fcnt_r;
        end
      end
      CLEAR: begin
        fcnt_nx_s = fcnt_r + {{(AW-1){1'b0}}, 1'b1};
        if (fcnt_r == AW'(NREGS-1)) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = CLEAR;
        end
      end
      default: begin
        state_nx_s = IDLE;
        fcnt_nx_s  = {AW{1'b0}};
      end
    endcase
  end

  // flush sequencer output decode
  always_comb begin
    idle_s  = 1'b0;
    clear_s = 1'b0;
    case (state_r)
      IDLE:    idle_s  = 1'b1;
      CLEAR:   clear_s = 1'b1;
      default: idle_s  = 1'b0;
    endcase
  end

  assign start_s    = idle_s & flush_req;
  assign flush_busy = clear_s;

  // register storage: write port 1 wins a collision, flush zeroes one entry per edge
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_r[i] <= {XLEN{1'b0}};
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (clear_s) begin
          if (fcnt_r == AW'(i)) mem_r[i] <= {XLEN{1'b0}};
        end else if (we1 && (wa1 == AW'(i))) begin
          mem_r[i] <= wd1;
        end else if (we0 && (wa0 == AW'(i))) begin
          mem_r[i] <= wd0;
        end
      end
    end
  end

  // busy scoreboard update: a new producer outranks a same-cycle writeback
  always_comb begin
    busy_nx_s = busy_r;
    for (int i = 0; i < NREGS; i++) begin
      if (i == 0) begin
        busy_nx_s[i] = 1'b0;
      end else if (iss_valid && (iss_addr == AW'(i))) begin
        busy_nx_s[i] = 1'b1;
      end else if ((we0 && (wa0 == AW'(i))) || (we1 && (wa1 == AW'(i)))) begin
        busy_nx_s[i] = 1'b0;
      end else begin
        busy_nx_s[i] = busy_r[i];
      end
    end
  end

  // busy scoreboard register; frozen while the flush runs
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      busy_r <= {NREGS{1'b0}};
    end else if (start_s) begin
      busy_r <= {NREGS{1'b0}};
    end else if (idle_s) begin
      busy_r <= busy_nx_s;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]   ra_s;
    logic [XLEN-1:0] base_data_s;
    logic            base_busy_s;
    logic [XLEN-1:0] data_s;
    logic            busy_s;

    assign ra_s        = rd_addr[p*AW +: AW];
    assign base_data_s = (ra_s == {AW{1'b0}}) ? {XLEN{1'b0}} : mem_r[ra_s];
    assign base_busy_s = (ra_s == {AW{1'b0}}) ? 1'b0 : busy_r[ra_s];

`ifdef REGFILE_BYPASS_EN
    logic fwd_ok_s;
    logic iss_hit_s;
    assign fwd_ok_s  = idle_s & ~reset & (ra_s != {AW{1'b0}});
    assign iss_hit_s = iss_valid & (iss_addr == ra_s);

    // read mux with same-cycle forwarding from the write ports
    always_comb begin
      data_s = base_data_s;
      busy_s = base_busy_s;
      if (fwd_ok_s && we1 && (wa1 == ra_s)) begin
        data_s = wd1;
        busy_s = iss_hit_s;
      end else if (fwd_ok_s && we0 && (wa0 == ra_s)) begin
        data_s = wd0;
        busy_s = iss_hit_s;
      end else begin
        data_s = base_data_s;
        busy_s = base_busy_s;
      end
    end
`else
    assign data_s = base_data_s;
    assign busy_s = base_busy_s;
`endif

    assign rd_data[p*XLEN +: XLEN] = data_s;
    assign rd_busy[p]              = clear_s | busy_s;
  end

endmodule
